// File: rtl/priority_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with valid/ready on both sides.
// Fixed MSB-first priority, or round-robin scanning downward from a rotating pointer.
module priority_encoder_rr #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N),
  localparam int CNT_W = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rr_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic             out_any,
  output logic             out_multi,
  output logic [CNT_W-1:0] out_count
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     onehot;
    logic             any;
    logic             multi;
    logic [CNT_W-1:0] count;
  } res_t;

  localparam logic [IDX_W-1:0] PTR_TOP = IDX_W'(N-1);

  logic             out_valid_q, out_valid_d;
  res_t             res_q, res_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             acc;
  logic [IDX_W-1:0] fix_idx, rr_idx, grant_idx;
  logic             rr_hit;
  logic [CNT_W-1:0] cnt;
  int               p;

  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;

  always_comb begin
    cnt     = '0;
    fix_idx = '0;
    rr_idx  = '0;
    rr_hit  = 1'b0;
    p       = 0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CNT_W'(in[i]);
      // upward scan: the last (highest) set bit overwrites earlier ones
      if (in[i]) fix_idx = IDX_W'(i);
    end
    for (int k = 0; k < N; k++) begin
      p = int'(ptr_q) - k;
      if (p < 0) p = p + N;
      if (!rr_hit && in[p]) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(p);
      end
    end
    grant_idx = rr_en ? rr_idx : fix_idx;

    res_d.any    = |in;
    res_d.count  = cnt;
    res_d.multi  = (cnt >= CNT_W'(2));
    res_d.idx    = res_d.any ? grant_idx : '0;
    res_d.onehot = res_d.any ? (N'(1) << grant_idx) : '0;

    ptr_d = ptr_q;
    if (acc && rr_en && res_d.any)
      ptr_d = (grant_idx == '0) ? PTR_TOP : grant_idx - IDX_W'(1);

    out_valid_d = out_valid_q;
    if (acc)            out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ptr_q       <= PTR_TOP;
    end else begin
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      if (acc) res_q <= res_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = res_q.idx;
  assign out_onehot = res_q.onehot;
  assign out_any    = res_q.any;
  assign out_multi  = res_q.multi;
  assign out_count  = res_q.count;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed bench for priority_encoder_rr (N=8) with hand-computed expectations.
module tb_priority_encoder_rr;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n, rr_en, in_valid, in_ready, out_valid, out_ready;
  logic       out_any, out_multi;
  logic [7:0] in, out_onehot;
  logic [2:0] out_idx;
  logic [3:0] out_count;

  int nvec = 0, nerr = 0;

  priority_encoder_rr #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .rr_en(rr_en), .in_valid(in_valid), .in_ready(in_ready),
    .in(in), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_onehot(out_onehot), .out_any(out_any), .out_multi(out_multi), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present one vector at a negedge and move to the next negedge
  task automatic step(input logic rr, input logic [7:0] v);
    rr_en = rr; in = v; in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; in = 'x;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_res(input string tag, input logic [2:0] idx, input logic [7:0] oh,
                         input logic any, input logic multi, input logic [3:0] cnt);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".idx"}, 32'(out_idx), 32'(idx));
    chk({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
    chk({tag, ".any"}, 32'(out_any), 32'(any));
    chk({tag, ".multi"}, 32'(out_multi), 32'(multi));
    chk({tag, ".count"}, 32'(out_count), 32'(cnt));
  endtask

  initial begin
    rst_n = 1'b0; rr_en = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.idx", 32'(out_idx), 32'd0);
    chk("rst.count", 32'(out_count), 32'd0);
    chk("rst.onehot", 32'(out_onehot), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // fixed priority
    step(1'b0, 8'b01110000); chk_res("t1", 3'd6, 8'b01000000, 1'b1, 1'b1, 4'd3);
    step(1'b0, 8'b00000000); chk_res("t2z", 3'd0, 8'b00000000, 1'b0, 1'b0, 4'd0);
    step(1'b0, 8'b00000001); chk_res("t2o", 3'd0, 8'b00000001, 1'b1, 1'b0, 4'd1);
    idle();
    chk("drain.valid", 32'(out_valid), 32'd0);
    chk("xhold.idx", 32'(out_idx), 32'd0);
    idle();
    chk("xhold.valid", 32'(out_valid), 32'd0);

    // round-robin back-to-back, ptr starts at 7
    step(1'b1, 8'b11000000); chk("t3a.idx", 32'(out_idx), 32'd7); chk("t3a.rdy", 32'(in_ready), 32'd1);
    step(1'b1, 8'b11000000); chk("t3b.idx", 32'(out_idx), 32'd6); chk("t3b.rdy", 32'(in_ready), 32'd1);
    step(1'b1, 8'b11000000); chk("t3c.idx", 32'(out_idx), 32'd7); chk("t3c.rdy", 32'(in_ready), 32'd1);
    // ptr now 6; a fixed-priority accept must leave it there
    step(1'b0, 8'b01000001); chk("rrkeep.fix", 32'(out_idx), 32'd6);
    step(1'b1, 8'b10000001); chk("rrkeep.rr", 32'(out_idx), 32'd0);
    step(1'b1, 8'b00000000); chk("rrzero.any", 32'(out_any), 32'd0);
    step(1'b1, 8'b10000001); chk("rrzero.idx", 32'(out_idx), 32'd7);
    idle();

    // wrap-around from a fresh ptr
    do_reset();
    step(1'b1, 8'b10000001); chk("t4a.idx", 32'(out_idx), 32'd7);
    step(1'b1, 8'b10000001); chk("t4b.idx", 32'(out_idx), 32'd0);
    step(1'b1, 8'b10000001); chk("t4c.idx", 32'(out_idx), 32'd7);
    idle();

    // backpressure
    out_ready = 1'b0;
    step(1'b0, 8'b00011000);
    in = 8'b00000010;
    for (int c = 0; c < 3; c++) begin
      chk("t5.rdy", 32'(in_ready), 32'd0);
      chk("t5.idx", 32'(out_idx), 32'd4);
      chk("t5.count", 32'(out_count), 32'd2);
      chk("t5.valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_res("t5n", 3'd1, 8'b00000010, 1'b1, 1'b0, 4'd1);
    idle();

    // async reset with a pending result
    do_reset();
    out_ready = 1'b0;
    step(1'b1, 8'b00100000); chk_res("t6g", 3'd5, 8'b00100000, 1'b1, 1'b0, 4'd1);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6r.valid", 32'(out_valid), 32'd0);
    chk("t6r.idx", 32'(out_idx), 32'd0);
    chk("t6r.onehot", 32'(out_onehot), 32'd0);
    chk("t6r.any", 32'(out_any), 32'd0);
    chk("t6r.count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6r.rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step(1'b1, 8'b11111111); chk_res("t6f", 3'd7, 8'b10000000, 1'b1, 1'b1, 4'd8);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
